pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, multiply/divide EX occupancy in cycles (legal 2..31).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum data-memory wait cycles before error (legal 1..255).
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- id_ex_memread  in  1  load in EX
- id_ex_rt  in  5  load destination in EX
- if_id_rs  in  5  rs of instruction in ID
- if_id_rt  in  5  rt of instruction in ID
- ex_mdu_start  in  1  multiply/divide in EX
- mem_req  in  1  load/store in MEM
- mem_ready  in  1  data memory completes this cycle
- stall  out  5  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB; 1 = hold
- mdu_busy  out  1  FSM in MDU_BUSY
- mem_err  out  1  sticky memory timeout flag
- stall_cycles  out  32  saturating count of stalled cycles

Function
REQ-004 SHALL implement FSM states IDLE, MDU_BUSY, MEM_WAIT.
REQ-005 SHALL compute stall combinationally from state and inputs; highest applicable priority wins: memory > MDU > load-use > none.
REQ-006 Memory wait: mem_req=1, mem_ready=0 and mem_err=0 SHALL drive stall=5'b01111; IDLE or MDU_BUSY SHALL then move to MEM_WAIT, saving the return state.
REQ-007 MEM_WAIT SHALL count wait cycles; mem_ready=1 SHALL return to the saved state; a count reaching MEM_TIMEOUT SHALL set mem_err, release stall, and return.
REQ-008 MDU: ex_mdu_start=1 in IDLE without a memory stall SHALL drive stall=5'b00111, load the counter with MDU_LAT-1, and enter MDU_BUSY.
REQ-009 In MDU_BUSY, stall SHALL be 5'b00111 while counter>1; the counter SHALL decrement each cycle, saturating at 1, including cycles spent in MEM_WAIT.
REQ-010 In MDU_BUSY with counter=1, stall SHALL be 0 unless a memory stall applies, and the FSM SHALL return to IDLE; total EX occupancy SHALL be exactly MDU_LAT cycles absent memory stalls.
REQ-011 ex_mdu_start SHALL be sampled only in IDLE, so a held instruction never retriggers the MDU.
REQ-012 Load-use hazard SHALL exist when id_ex_memread=1, id_ex_rt!=0, and id_ex_rt equals if_id_rs or if_id_rt.
REQ-013 A load-use hazard with no higher-priority stall SHALL drive stall=5'b00011 for that cycle only, with no state change.
REQ-014 stall_cycles SHALL increment on every cycle with stall!=0 and saturate at 32'hFFFFFFFF.
REQ-015 mem_err SHALL clear only on reset; while mem_err=1, memory stalls SHALL be suppressed.

Reset
REQ-016 reset=0 SHALL asynchronously force: state IDLE, all counters 0, mem_err=0, stall_cycles=0.
REQ-017 During reset, stall SHALL be 0 and mdu_busy SHALL be 0.
REQ-018 Reset asserted mid-MDU or mid-MEM_WAIT SHALL abort that operation with no residual stall after release.

Configuration
REQ-019 Macro PIPE_STALL_MDU_EN SHALL compile the MDU path in when defined.
REQ-020 With PIPE_STALL_MDU_EN undefined, ex_mdu_start SHALL be ignored, MDU_BUSY SHALL be unreachable, and mdu_busy SHALL be tied to 0.

Structure
REQ-021 A shared package SHALL hold the state enumeration, the stall-vector constants (STALL_NONE, STALL_LOADUSE=5'b00011, STALL_MDU=5'b00111, STALL_MEM=5'b01111) and the 5-bit stage-index constants.
REQ-022 The load-use comparator SHALL be the single sub-module hazard_detect, purely combinational.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load-use: id_ex_memread=1, id_ex_rt=5, if_id_rs=5 -> stall=5'b00011 for exactly one cycle; same with rt=0 -> stall=0.
- MDU: MDU_LAT=4, ex_mdu_start pulse in IDLE -> stall=5'b00111 for 3 cycles, then 0; mdu_busy high 3 cycles; no retrigger while start is held.
- Memory wait: mem_req=1 with mem_ready low 3 cycles -> stall=5'b01111 for 3 cycles, released in the cycle mem_ready=1; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready never asserts -> mem_err=1 after 4 wait cycles, stall=0 afterwards.
- Overlap: memory wait of 2 cycles starting in the 2nd MDU_BUSY cycle with MDU_LAT=4 -> stall=5'b01111 for 2 cycles, then 0, FSM back in IDLE, 4 total stalled cycles.
- Reset mid-MDU: reset=0 in MDU_BUSY -> stall=0 immediately; after release, state IDLE and stall_cycles=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall
//                controller: FSM state enumeration, per-stage stall vectors
//                and stage indices into the 5-bit stall vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MDU_BUSY = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

   // Stage indices into the stall vector
   localparam logic [4:0] STG_PC    = 5'd0;
   localparam logic [4:0] STG_IFID  = 5'd1;
   localparam logic [4:0] STG_IDEX  = 5'd2;
   localparam logic [4:0] STG_EXMEM = 5'd3;
   localparam logic [4:0] STG_MEMWB = 5'd4;

   // Stall vectors, 1 = hold that stage
   localparam logic [4:0] STALL_NONE    = 5'b00000;
   localparam logic [4:0] STALL_LOADUSE = 5'b00011;
   localparam logic [4:0] STALL_MDU     = 5'b00111;
   localparam logic [4:0] STALL_MEM     = 5'b01111;

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use comparator. Flags a hazard when the load in EX
//                writes a non-zero register that the instruction in ID reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect (
   input  logic       id_ex_memread_i,
   input  logic [4:0] id_ex_rt_i,
   input  logic [4:0] if_id_rs_i,
   input  logic [4:0] if_id_rt_i,
   output logic       hazard_o
);

   // Register 0 is hard-wired, so a load into it never creates a dependency
   assign hazard_o = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                     ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Pipeline stall controller. Arbitrates memory-wait, multi-
//                cycle multiply/divide and load-use stalls (in that priority)
//                and counts stalled cycles. The MDU path is compiled in only
//                when the macro PIPE_STALL_MDU_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MDU_LAT     = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_ex_memread,
   input  logic [4:0]  id_ex_rt,
   input  logic [4:0]  if_id_rs,
   input  logic [4:0]  if_id_rt,
   input  logic        ex_mdu_start,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic [4:0]  stall,
   output logic        mdu_busy,
   output logic        mem_err,
   output logic [31:0] stall_cycles
);

   localparam logic [4:0] c_mdu_load = 5'(MDU_LAT - 1);
   localparam logic [7:0] c_mem_to   = 8'(MEM_TIMEOUT);

   state_e      state_q, state_d;
   state_e      ret_q, ret_d;
   state_e      home;
   logic [4:0]  mdu_cnt_q, mdu_cnt_d;
   logic [7:0]  mem_cnt_q, mem_cnt_d;
   logic [7:0]  mem_cnt_nx;
   logic        mem_err_q, mem_err_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [4:0]  stall_raw;
   logic        hazard;
   logic        mem_stall;
   logic        mdu_start;

   hazard_detect u_hazard (
      .id_ex_memread_i (id_ex_memread),
      .id_ex_rt_i      (id_ex_rt),
      .if_id_rs_i      (if_id_rs),
      .if_id_rt_i      (if_id_rt),
      .hazard_o        (hazard)
   );

`ifdef PIPE_STALL_MDU_EN
   assign mdu_start = ex_mdu_start;
   assign mdu_busy  = (state_q == ST_MDU_BUSY);
`else
   logic unused_mdu_start;
   assign unused_mdu_start = ex_mdu_start;
   assign mdu_start        = 1'b0;
   assign mdu_busy         = 1'b0;
`endif

   // Once the timeout flag is set the memory is treated as never stalling
   assign mem_stall = mem_req && !mem_ready && !mem_err_q;

   // Next-state and stall arbitration: base stall from state, memory overrides
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      mdu_cnt_d  = mdu_cnt_q;
      mem_cnt_d  = '0;
      mem_err_d  = mem_err_q;
      stall_raw  = STALL_NONE;
      home       = ST_IDLE;
      mem_cnt_nx = 8'd1;

      case (state_q)
         ST_IDLE: begin
            home = ST_IDLE;
            if (mdu_start && !mem_stall) begin
               stall_raw = STALL_MDU;
               mdu_cnt_d = c_mdu_load;
               state_d   = ST_MDU_BUSY;
            end else if (hazard) begin
               stall_raw = STALL_LOADUSE;
            end
         end
         ST_MDU_BUSY: begin
            if (mdu_cnt_q > 5'd1) begin
               home      = ST_MDU_BUSY;
               stall_raw = STALL_MDU;
               mdu_cnt_d = mdu_cnt_q - 5'd1;
            end else begin
               home    = ST_IDLE;
               state_d = ST_IDLE;
               if (hazard) stall_raw = STALL_LOADUSE;
            end
         end
         ST_MEM_WAIT: begin
            // The MDU keeps counting down while the memory holds the pipe
            home    = ret_q;
            state_d = ret_q;
            if ((ret_q == ST_MDU_BUSY) && (mdu_cnt_q > 5'd1)) begin
               stall_raw = STALL_MDU;
               mdu_cnt_d = mdu_cnt_q - 5'd1;
            end else if (hazard) begin
               stall_raw = STALL_LOADUSE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (mem_stall) begin
         stall_raw  = STALL_MEM;
         mem_cnt_nx = ((state_q == ST_MEM_WAIT) ? mem_cnt_q : 8'd0) + 8'd1;
         if (mem_cnt_nx == c_mem_to) begin
            mem_err_d = 1'b1;
            state_d   = home;
         end else begin
            mem_cnt_d = mem_cnt_nx;
            ret_d     = home;
            state_d   = ST_MEM_WAIT;
         end
      end

      stall_cnt_d = stall_cnt_q;
      if ((stall_raw != STALL_NONE) && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Stall is forced low while reset is held
   assign stall        = reset ? stall_raw : STALL_NONE;
   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_cnt_q;

   // State and counter registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ret_q       <= ST_IDLE;
         mdu_cnt_q   <= '0;
         mem_cnt_q   <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         mdu_cnt_q   <= mdu_cnt_d;
         mem_cnt_q   <= mem_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl: directed scenarios
//                with literal expectations plus randomized traffic compared
//                every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;
   import pipe_stall_ctrl_pkg::*;

   localparam int LAT = 4;
   localparam int TO  = 4;
`ifdef PIPE_STALL_MDU_EN
   localparam bit MDU_ON = 1'b1;
`else
   localparam bit MDU_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        id_ex_memread = 1'b0;
   logic [4:0]  id_ex_rt = '0;
   logic [4:0]  if_id_rs = '0;
   logic [4:0]  if_id_rt = '0;
   logic        ex_mdu_start = 1'b0;
   logic        mem_req = 1'b0;
   logic        mem_ready = 1'b0;
   logic [4:0]  stall;
   logic        mdu_busy;
   logic        mem_err;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_pass   = 0;

   pipe_stall_ctrl #(.MDU_LAT(LAT), .MEM_TIMEOUT(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_ex_memread (id_ex_memread),
      .id_ex_rt      (id_ex_rt),
      .if_id_rs      (if_id_rs),
      .if_id_rt      (if_id_rt),
      .ex_mdu_start  (ex_mdu_start),
      .mem_req       (mem_req),
      .mem_ready     (mem_ready),
      .stall         (stall),
      .mdu_busy      (mdu_busy),
      .mem_err       (mem_err),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // m_mdu_on : a multiply/divide still occupies EX; m_left : occupancy left
   // m_wait   : a memory wait began on an earlier cycle; m_wn : waits so far
   bit      m_mdu_on, m_wait, m_err;
   int      m_left, m_wn;
   longint  m_sc;

   initial begin
      bit         lu, ms, start_now, mdu_hold;
      bit         n_mdu_on, n_wait, n_err;
      int         n_left, n_wn, w;
      longint     n_sc;
      logic [4:0] e_stall;
      m_mdu_on = 0; m_wait = 0; m_err = 0; m_left = 0; m_wn = 0; m_sc = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_mdu_on = 0; m_wait = 0; m_err = 0; m_left = 0; m_wn = 0; m_sc = 0;
         end
         lu        = id_ex_memread && (id_ex_rt != 0) &&
                     (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
         ms        = reset && mem_req && !mem_ready && !m_err;
         start_now = MDU_ON && reset && ex_mdu_start && !m_mdu_on && !m_wait && !ms;
         mdu_hold  = m_mdu_on && (m_left > 1);
         if (!reset)                      e_stall = STALL_NONE;
         else if (ms)                     e_stall = STALL_MEM;
         else if (mdu_hold || start_now)  e_stall = STALL_MDU;
         else if (lu)                     e_stall = STALL_LOADUSE;
         else                             e_stall = STALL_NONE;

         check("model_stall", stall, e_stall);
         check("model_mdu_busy", mdu_busy, m_mdu_on && !m_wait);
         check("model_mem_err", mem_err, m_err);
         check("model_stall_cycles", stall_cycles, m_sc[31:0]);

         n_mdu_on = m_mdu_on; n_left = m_left; n_wait = m_wait;
         n_wn = m_wn; n_err = m_err; n_sc = m_sc;
         if (start_now) begin
            n_mdu_on = 1; n_left = LAT - 1;
         end else if (m_mdu_on) begin
            if (!m_wait && m_left <= 1) n_mdu_on = 0;
            else n_left = (m_left > 1) ? m_left - 1 : 1;
         end
         if (ms) begin
            w = (m_wait ? m_wn : 0) + 1;
            if (w >= TO) begin
               n_err = 1; n_wait = 0; n_wn = 0;
            end else begin
               n_wait = 1; n_wn = w;
            end
         end else begin
            n_wait = 0; n_wn = 0;
         end
         if (e_stall != STALL_NONE && n_sc < 64'hFFFF_FFFF) n_sc = n_sc + 1;

         @(posedge clk);
         if (reset) begin
            m_mdu_on = n_mdu_on; m_left = n_left; m_wait = n_wait;
            m_wn = n_wn; m_err = n_err; m_sc = n_sc;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_ex_memread = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
      ex_mdu_start = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      tick();
      reset = 0;
      idle_inputs();
      tick();
      tick();
      reset = 1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state, with a would-be memory stall present on the inputs
      reset = 0;
      mem_req = 1; mem_ready = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_stall", stall, 5'b00000);
      check("rst_mdu_busy", mdu_busy, 0);
      check("rst_mem_err", mem_err, 0);
      check("rst_stall_cycles", stall_cycles, 0);
      tick();
      idle_inputs();
      reset = 1;

      // Load-use: match on rs, release, rt=0 no hazard, match on rt
      tick();
      id_ex_memread = 1; id_ex_rt = 5; if_id_rs = 5; if_id_rt = 9;
      @(negedge clk); check("lu_rs_stall", stall, 5'b00011);
      tick(); id_ex_memread = 0;
      @(negedge clk); check("lu_release", stall, 5'b00000);
      tick(); id_ex_memread = 1; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
      @(negedge clk); check("lu_rt0", stall, 5'b00000);
      tick(); id_ex_rt = 7; if_id_rs = 1; if_id_rt = 7;
      @(negedge clk); check("lu_rt_stall", stall, 5'b00011);
      tick(); idle_inputs();
      @(negedge clk); check("lu_count", stall_cycles, 2);

      // MDU: start held while stalled, dropped once the pipe advances
      do_reset();
      for (int k = 0; k < 5; k++) begin
         ex_mdu_start = (k < 4);
         @(negedge clk);
         check("mdu_stall", stall, (MDU_ON && k < 3) ? STALL_MDU : STALL_NONE);
         check("mdu_busy", mdu_busy, MDU_ON && k >= 1 && k <= 3);
         tick();
      end
      idle_inputs();
      @(negedge clk); check("mdu_count", stall_cycles, MDU_ON ? 3 : 0);

      // Memory wait of 3 cycles, released when ready arrives
      do_reset();
      for (int k = 0; k < 4; k++) begin
         mem_req = 1; mem_ready = (k == 3);
         @(negedge clk);
         check("memwait_stall", stall, (k < 3) ? STALL_MEM : STALL_NONE);
         tick();
      end
      idle_inputs();
      @(negedge clk);
      check("memwait_count", stall_cycles, 3);
      check("memwait_no_err", mem_err, 0);

      // Timeout: ready never comes
      do_reset();
      for (int k = 0; k < 6; k++) begin
         mem_req = 1; mem_ready = 0;
         @(negedge clk);
         check("timeout_stall", stall, (k < 4) ? STALL_MEM : STALL_NONE);
         check("timeout_err", mem_err, k >= 4);
         tick();
      end
      idle_inputs();
      @(negedge clk); check("timeout_count", stall_cycles, 4);

      // Overlap: 2-cycle memory wait starting in the 2nd MDU_BUSY cycle
      do_reset();
      for (int k = 0; k < 7; k++) begin
         ex_mdu_start = (k <= 4);
         mem_req      = (k >= 2 && k <= 4);
         mem_ready    = (k == 4);
         @(negedge clk);
         check("ovl_stall", stall,
               (k < 2) ? (MDU_ON ? STALL_MDU : STALL_NONE) :
               (k < 4) ? STALL_MEM : STALL_NONE);
         check("ovl_busy", mdu_busy, MDU_ON && (k == 1 || k == 2 || k == 5));
         tick();
      end
      idle_inputs();
      @(negedge clk); check("ovl_count", stall_cycles, MDU_ON ? 4 : 2);

      // Reset mid-MDU
      do_reset();
      ex_mdu_start = 1;
      @(negedge clk); check("rmdu_pre", stall, MDU_ON ? STALL_MDU : STALL_NONE);
      tick();
      #2;
      reset = 0;
      #1;
      check("rmdu_stall", stall, 5'b00000);
      check("rmdu_busy", mdu_busy, 0);
      check("rmdu_count", stall_cycles, 0);
      tick();
      ex_mdu_start = 0;
      reset = 1;
      @(negedge clk);
      check("rmdu_post_stall", stall, 5'b00000);
      check("rmdu_post_count", stall_cycles, 0);
      tick();
      @(negedge clk); check("rmdu_post_busy", mdu_busy, 0);

      // Randomized traffic with occasional resets
      do_reset();
      repeat (3000) begin
         id_ex_memread = 1'($urandom_range(0, 1));
         id_ex_rt      = 5'($urandom_range(0, 3));
         if_id_rs      = 5'($urandom_range(0, 3));
         if_id_rt      = 5'($urandom_range(0, 3));
         ex_mdu_start  = ($urandom_range(0, 3) == 0);
         mem_req       = ($urandom_range(0, 2) == 0);
         mem_ready     = ($urandom_range(0, 1) == 0);
         reset         = ($urandom_range(0, 149) != 0);
         tick();
      end
      reset = 1;
      idle_inputs();
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
